// File: rtl/toy_bus_age_arb_n.sv
// toy_bus_age_arb_n: N-input valid/ready arbiter with least-recently-granted
// fairness kept in an NxN age matrix. Merges bus master requests onto one
// target port.
// Optional build macro TOY_BUS_AGE_ARB_OUT_REG_EN adds a one-entry output
// register slice and drops the grant hold; without it the output path is
// combinational and the grant is held while the target back-pressures.
module toy_bus_age_arb_n #(
  parameter int NUM_IN = 4,
  parameter int PLD_W  = 77
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_vld,
  output logic [NUM_IN-1:0]       in_rdy,
  input  logic [NUM_IN*PLD_W-1:0] in_pld,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [PLD_W-1:0]        out_pld,
  output logic [NUM_IN-1:0]       out_sel
);

  // age_q[i][j] = 1 means requester j is older than requester i
  logic [NUM_IN-1:0] age_q   [NUM_IN];
  logic [NUM_IN-1:0] age_nxt [NUM_IN];
  logic [NUM_IN-1:0] sel;
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] acc;
  logic [PLD_W-1:0]  mux_pld;

  // A valid requester wins when no valid requester is older than it
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel[i] = in_vld[i] & ~|(age_q[i] & in_vld);
    end
  end

  // AND-OR payload mux; yields zero when nothing is granted
  always_comb begin
    mux_pld = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mux_pld = mux_pld | (in_pld[i*PLD_W +: PLD_W] & {PLD_W{grant[i]}});
    end
  end

  // Accepted requester becomes youngest: its row goes to 1, its column to 0
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      age_nxt[i] = age_q[i];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (i != j) begin
          if (acc[i]) begin
            age_nxt[i][j] = 1'b1;
          end else if (acc[j]) begin
            age_nxt[i][j] = 1'b0;
          end
        end
      end
    end
  end

  // Age matrix register; reset leaves index 0 oldest, diagonal stays 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        for (int j = 0; j < NUM_IN; j++) begin
          age_q[i][j] <= (j < i);
        end
      end
    end else if (|acc) begin
      for (int i = 0; i < NUM_IN; i++) begin
        age_q[i] <= age_nxt[i];
      end
    end
  end

`ifdef TOY_BUS_AGE_ARB_OUT_REG_EN

  logic              out_vld_q;
  logic [PLD_W-1:0]  out_pld_q;
  logic [NUM_IN-1:0] out_sel_q;
  logic              slice_en;

  assign slice_en = !out_vld_q || out_rdy;

  // Grant straight from the age matrix; nothing is granted during reset
  always_comb begin
    grant = '0;
    if (rst_n) begin
      grant = sel;
    end
  end

  assign in_rdy = grant & {NUM_IN{slice_en}};
  assign acc    = in_vld & in_rdy;

  // Output slice loads whenever it is empty or being drained this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      out_sel_q <= '0;
    end else if (slice_en) begin
      out_vld_q <= |grant;
      out_pld_q <= mux_pld;
      out_sel_q <= grant;
    end
  end

  assign out_vld = out_vld_q;
  assign out_pld = out_pld_q;
  assign out_sel = out_sel_q;

`else

  logic              lock_q;
  logic [NUM_IN-1:0] gnt_q;

  // While locked the held grant wins, masked off if its requester drops vld
  always_comb begin
    grant = '0;
    if (rst_n) begin
      grant = lock_q ? (gnt_q & in_vld) : sel;
    end
  end

  assign out_vld = |(in_vld & grant);
  assign out_pld = mux_pld;
  assign out_sel = grant;
  assign in_rdy  = grant & {NUM_IN{out_rdy}};
  assign acc     = in_vld & in_rdy;

  // Hold the grant under backpressure so out_pld stays stable until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end else if (!lock_q) begin
      if (out_vld && !out_rdy) begin
        lock_q <= 1'b1;
        gnt_q  <= grant;
      end
    end else if (out_vld && out_rdy) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end else if (~|(gnt_q & in_vld)) begin
      lock_q <= 1'b0;
      gnt_q  <= '0;
    end
  end

`endif

endmodule

// File: tb/tb_toy_bus_age_arb_n.sv
// Testbench for toy_bus_age_arb_n in its default (combinational, grant-hold)
// build. The reference model keeps requesters in a queue ordered oldest to
// youngest and a simple locked/index pair for the grant hold.
module tb_toy_bus_age_arb_n;
  localparam int N = 4;
  localparam int W = 77;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_vld;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_pld;
  logic           out_vld;
  logic           out_rdy;
  logic [W-1:0]   out_pld;
  logic [N-1:0]   out_sel;

  toy_bus_age_arb_n #(.NUM_IN(N), .PLD_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_pld  (in_pld),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_pld (out_pld),
    .out_sel (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] pldArr [N];
  int           order[$];
  bit           locked;
  int           lockIdx;
  logic [N-1:0] lastAcc;
  logic [N-1:0] expGrant;
  logic         expVld;
  logic [W-1:0] expPld;
  logic [N-1:0] expRdy;
  logic [W-1:0] heldPld;
  int           testCount;
  int           failCount;

  function automatic logic [W-1:0] randPld();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  function automatic int oneHotIdx(input logic [N-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  task automatic modelReset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    locked  = 1'b0;
    lockIdx = 0;
    lastAcc = '0;
  endtask

  // Oldest valid requester wins, unless a grant is being held
  function automatic logic [N-1:0] computeGrant();
    logic [N-1:0] g;
    bit found;
    g = '0;
    found = 1'b0;
    if (rst_n) begin
      if (locked) begin
        if (in_vld[lockIdx]) g[lockIdx] = 1'b1;
      end else begin
        foreach (order[k]) begin
          if (!found && in_vld[order[k]]) begin
            g[order[k]] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
    return g;
  endfunction

  task automatic packPld();
    for (int i = 0; i < N; i++) in_pld[i*W +: W] = pldArr[i];
  endtask

  // Drive new inputs; a payload may only change when its request is not pending
  task automatic applyStimulus(input logic [N-1:0] vld, input logic rdy);
    for (int i = 0; i < N; i++) begin
      if (!(in_vld[i] && !lastAcc[i])) pldArr[i] = randPld();
    end
    in_vld  = vld;
    out_rdy = rdy;
    packPld();
  endtask

  task automatic checkOutput(input string tag);
    int idx;
    expGrant = computeGrant();
    idx      = oneHotIdx(expGrant);
    expVld   = |expGrant;
    expPld   = (idx >= 0) ? pldArr[idx] : '0;
    expRdy   = expGrant & {N{out_rdy}};
    testCount++;
    assert (out_sel === expGrant) else begin
      failCount++;
      $error("[TB] FAIL %s out_sel observed=%b expected=%b", tag, out_sel, expGrant);
    end
    testCount++;
    assert (out_vld === expVld) else begin
      failCount++;
      $error("[TB] FAIL %s out_vld observed=%b expected=%b", tag, out_vld, expVld);
    end
    testCount++;
    assert (out_pld === expPld) else begin
      failCount++;
      $error("[TB] FAIL %s out_pld observed=%h expected=%h", tag, out_pld, expPld);
    end
    testCount++;
    assert (in_rdy === expRdy) else begin
      failCount++;
      $error("[TB] FAIL %s in_rdy observed=%b expected=%b", tag, in_rdy, expRdy);
    end
  endtask

  // Advance the model by one clock using the inputs seen this cycle
  task automatic modelUpdate();
    int g;
    lastAcc = '0;
    if (!rst_n) begin
      modelReset();
    end else if (expVld && out_rdy) begin
      g = oneHotIdx(expGrant);
      lastAcc = expGrant;
      foreach (order[k]) begin
        if (order[k] == g) begin
          order.delete(k);
          break;
        end
      end
      order.push_back(g);
      locked = 1'b0;
    end else if (!locked && expVld && !out_rdy) begin
      locked  = 1'b1;
      lockIdx = oneHotIdx(expGrant);
    end else if (locked && !in_vld[lockIdx]) begin
      locked = 1'b0;
    end
  endtask

  task automatic runCycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycleSel(input string tag, input logic [N-1:0] want);
    @(negedge clk);
    checkOutput(tag);
    testCount++;
    assert (out_sel === want) else begin
      failCount++;
      $error("[TB] FAIL %s directed out_sel observed=%b expected=%b", tag, out_sel, want);
    end
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] seq1 [8];
  logic [N-1:0] rv;

  initial begin
    testCount = 0;
    failCount = 0;
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n   = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b0;
    for (int i = 0; i < N; i++) pldArr[i] = randPld();
    packPld();
    modelReset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Outputs stay zero in reset even with every request raised
    applyStimulus(4'b1111, 1'b1);
    runCycle("reset0");
    runCycle("reset1");
    rst_n = 1'b1;

    // Round robin through all four requesters
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1'b1);
      runCycleSel("rr", seq1[k]);
    end

    // Backpressure holds grant and payload
    applyStimulus(4'b0101, 1'b0);
    heldPld = pldArr[0];
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0101, 1'b0);
      testCount++;
      assert (in_pld[W-1:0] === heldPld) else begin
        failCount++;
        $error("[TB] FAIL hold_stim in_pld0 observed=%h expected=%h", in_pld[W-1:0], heldPld);
      end
      @(negedge clk);
      testCount++;
      assert (out_pld === heldPld) else begin
        failCount++;
        $error("[TB] FAIL hold_pld observed=%h expected=%h", out_pld, heldPld);
      end
      checkOutput("hold");
      modelUpdate();
      @(posedge clk);
      #1;
    end
    applyStimulus(4'b0101, 1'b1);
    runCycleSel("hold_release", 4'b0001);
    applyStimulus(4'b0101, 1'b1);
    runCycleSel("after_release", 4'b0100);
    applyStimulus(4'b0001, 1'b1);
    runCycleSel("drain0", 4'b0001);

    // Youngest requester loses to an older one
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, 1'b1);
      runCycleSel("only2", 4'b0100);
    end
    applyStimulus(4'b0110, 1'b1);
    runCycleSel("older1", 4'b0010);
    applyStimulus(4'b0100, 1'b1);
    runCycleSel("drain2", 4'b0100);

    // Locked requester drops its request
    applyStimulus(4'b0001, 1'b0);
    runCycleSel("lock0", 4'b0001);
    applyStimulus(4'b0000, 1'b0);
    runCycleSel("drop0", 4'b0000);
    applyStimulus(4'b0010, 1'b1);
    runCycleSel("unlocked", 4'b0010);

    // Reset in the middle of a locked grant
    applyStimulus(4'b1000, 1'b0);
    runCycleSel("lock3", 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid");
    testCount++;
    assert (out_vld === 1'b0) else begin
      failCount++;
      $error("[TB] FAIL reset_mid_vld observed=%b expected=0", out_vld);
    end
    modelReset();
    @(posedge clk);
    #1;
    runCycle("reset_hold");
    rst_n = 1'b1;
    applyStimulus(4'b1001, 1'b1);
    runCycleSel("post_reset", 4'b0001);

    // Random traffic obeying the valid/ready protocol
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (in_vld[i] && !lastAcc[i]) rv[i] = 1'b1;
        else rv[i] = ($urandom_range(0, 1) == 1);
      end
      applyStimulus(rv, ($urandom_range(0, 3) != 0));
      runCycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
